// File: rtl/monitor_conflito.sv
// Conflict monitor: synchronises the comparator mismatch flag, confirms persistent
// mismatches as conflicts, latches an acknowledgeable alarm and counts conflicts.
module monitor_conflito #(
  parameter int unsigned FILTRO = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       diferente,
  input  logic       ack,
  output logic       alarme,
  output logic       conflito,
  output logic [7:0] eventos,
  output logic [1:0] estado
);

  typedef enum logic [1:0] {
    IDLE        = 2'b00,
    VERIFICA    = 2'b01,
    ALARME      = 2'b10,
    RECONHECIDO = 2'b11
  } estado_t;

  localparam logic [7:0] LIMITE = 8'(FILTRO - 1);

  logic       s1;
  logic       ds;
  estado_t    state;
  estado_t    state_next;
  logic [7:0] cnt;
  logic [7:0] cnt_next;
  logic       confirma;

  // diferente comes from switches: two flops before anything decodes it.
  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge value of its source, which is what makes the chain a 2-stage delay.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      ds <= 1'b0;
    end else begin
      s1 <= diferente;
      ds <= s1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      eventos <= 8'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (confirma && eventos != 8'hFF) eventos <= eventos + 8'd1;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    confirma   = 1'b0;
    unique case (state)
      IDLE: begin
        if (ds) begin
          if (FILTRO == 1) begin
            state_next = ALARME;
            confirma   = 1'b1;
          end else begin
            state_next = VERIFICA;
            cnt_next   = 8'd1;
          end
        end else begin
          cnt_next = 8'd0;
        end
      end
      VERIFICA: begin
        if (!ds) begin
          state_next = IDLE;
          cnt_next   = 8'd0;
        end else if (cnt == LIMITE) begin
          state_next = ALARME;
          confirma   = 1'b1;
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
      ALARME: begin
        // Latched: only an acknowledge leaves, regardless of ds.
        if (ack) begin
          state_next = ds ? RECONHECIDO : IDLE;
          cnt_next   = 8'd0;
        end
      end
      RECONHECIDO: begin
        if (!ds) begin
          state_next = IDLE;
          cnt_next   = 8'd0;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 8'd0;
      end
    endcase
  end

  assign alarme   = (state == ALARME);
  assign conflito = state[1];
  assign estado   = state;

endmodule
